// File: rtl/bk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_pkg : shared types and helpers for the Brent-Kung subtractor datapath.
// Rev 1.0
// ---------------------------------------------------------------------------
package bk_pkg;

  localparam int BK_STAGES = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Prefix tree depth: smallest l with 2**l >= w.
  function automatic int bk_levels(input int w);
    int l;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < w) l = i + 1;
    end
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bk_subtractor_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_subtractor_pipe_if : operand/result handshake bundle (ovf under BK_SUB_OVF_EN).
// Rev 1.0
// ---------------------------------------------------------------------------
interface bk_subtractor_pipe_if #(
  parameter int WIDTH = 24
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bout;
`ifdef BK_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, A, B, bin, out_ready,
`ifdef BK_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, D, bout
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
`ifdef BK_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, D, bout
  );

endinterface
`default_nettype wire

// File: rtl/bk_gp_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_gp_cell : prefix operator combining a high group with the group below it.
// Rev 1.0
// ---------------------------------------------------------------------------
module bk_gp_cell
  import bk_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t gp
);

  assign gp.g = hi.g | (hi.p & lo.g);
  assign gp.p = hi.p & lo.p;

endmodule
`default_nettype wire

// File: rtl/bk_subtractor_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_subtractor_pipe : 3-stage Brent-Kung D = A - B - bin; optional ovf via BK_SUB_OVF_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  bk_subtractor_pipe_if.slave bus
);

  localparam int LV = bk_levels(WIDTH);

  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3           = !v3 | bus.out_ready;
  assign en2           = !v2 | en3;
  assign en1           = !v1 | en2;
  assign bus.in_ready  = en1;
  assign bus.out_valid = v3;

  // S1: subtraction as A + ~B + ~bin
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;
`ifdef BK_SUB_OVF_EN
  logic             s1_am, s1_bm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      s1_p  <= '0;
      s1_g  <= '0;
      s1_c0 <= 1'b0;
`ifdef BK_SUB_OVF_EN
      s1_am <= 1'b0;
      s1_bm <= 1'b0;
`endif
    end else if (en1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_p  <= bus.A ^ ~bus.B;
        s1_g  <= bus.A & ~bus.B;
        s1_c0 <= ~bus.bin;
`ifdef BK_SUB_OVF_EN
        s1_am <= bus.A[WIDTH-1];
        s1_bm <= bus.B[WIDTH-1];
`endif
      end
    end
  end

  // Carry-in folded into bit 0 so every prefix G[i:0] is directly carry i+1.
  gp_t up [0:LV][0:WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    if (i == 0) begin : g_cin
      assign up[0][i] = {s1_g[0] | (s1_p[0] & s1_c0), s1_p[0]};
    end else begin : g_bit
      assign up[0][i] = {s1_g[i], s1_p[i]};
    end
  end

  for (genvar l = 1; l <= LV; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (((i + 1) % (1 << l)) == 0) begin : g_cell
        bk_gp_cell u_cell (
          .hi (up[l-1][i]),
          .lo (up[l-1][i - (1 << (l - 1))]),
          .gp (up[l][i])
        );
      end else begin : g_pass
        assign up[l][i] = up[l-1][i];
      end
    end
  end

  gp_t              s2_up [0:WIDTH-1];
  logic [WIDTH-1:0] s2_p;
  logic             s2_c0;
`ifdef BK_SUB_OVF_EN
  logic             s2_am, s2_bm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      for (int i = 0; i < WIDTH; i++) s2_up[i] <= '0;
      s2_p  <= '0;
      s2_c0 <= 1'b0;
`ifdef BK_SUB_OVF_EN
      s2_am <= 1'b0;
      s2_bm <= 1'b0;
`endif
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        for (int i = 0; i < WIDTH; i++) s2_up[i] <= up[LV][i];
        s2_p  <= s1_p;
        s2_c0 <= s1_c0;
`ifdef BK_SUB_OVF_EN
        s2_am <= s1_am;
        s2_bm <= s1_bm;
`endif
      end
    end
  end

  // S3 down-sweep: fill the positions the up-sweep left as partial groups.
  gp_t dn [1:LV][0:WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_dtop
    assign dn[LV][i] = s2_up[i];
  end

  for (genvar l = 1; l < LV; l++) begin : g_dn
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && ((i + 1) > (1 << l))) begin : g_cell
        bk_gp_cell u_cell (
          .hi (dn[l+1][i]),
          .lo (dn[l+1][i - (1 << (l - 1))]),
          .gp (dn[l][i])
        );
      end else begin : g_pass
        assign dn[l][i] = dn[l+1][i];
      end
    end
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] d_next;

  assign c[0] = s2_c0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i+1] = dn[1][i].g;
  end
  assign d_next = s2_p ^ c[WIDTH-1:0];

  logic [WIDTH-1:0] d_q;
  logic             bout_q;
`ifdef BK_SUB_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
`ifdef BK_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        d_q    <= d_next;
        bout_q <= ~c[WIDTH];
`ifdef BK_SUB_OVF_EN
        ovf_q  <= (s2_am != s2_bm) & (d_next[WIDTH-1] != s2_am);
`endif
      end
    end
  end

  assign bus.D    = d_q;
  assign bus.bout = bout_q;
`ifdef BK_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bk_subtractor_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bk_subtractor_pipe : directed + random self-checking bench for bk_subtractor_pipe.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bk_subtractor_pipe;

  localparam int W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  bk_subtractor_pipe_if #(.WIDTH(W)) bus ();

  bk_subtractor_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with out_ready high; result sampled 3 edges after presentation.
  task automatic run1(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bi, input logic [W-1:0] ed, input logic eb);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.bin       = bi;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".D"},     64'(bus.D),         64'(ed));
    chk({tag, ".bout"},  64'(bus.bout),      64'(eb));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [W:0] q [$];
  logic [W:0] exp_r;
  int         sent, got, pass, cyc;
  logic       need;

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.D",     64'(bus.D),         64'd0);
    chk("rst.bout",  64'(bus.bout),      64'd0);
`ifdef BK_SUB_OVF_EN
    chk("rst.ovf",   64'(bus.ovf),       64'd0);
`endif
    #3 rst_n = 1'b1;
    step();
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);

    // Basic with explicit latency
    bus.in_valid = 1'b1;
    bus.A = 24'h000005; bus.B = 24'h000003; bus.bin = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("lat.c1", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat.c2", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat.c3", 64'(bus.out_valid), 64'd1);
    chk("basic.D",    64'(bus.D),    64'h000002);
    chk("basic.bout", 64'(bus.bout), 64'd0);
    step();
    chk("basic.drain", 64'(bus.out_valid), 64'd0);

    // Arithmetic corners
    run1("wrap1", 24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1);
    run1("wrap2", 24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1);
    run1("eq",    24'hABCDEF, 24'hABCDEF, 1'b0, 24'h000000, 1'b0);
    run1("mix",   24'h123456, 24'h000456, 1'b1, 24'h122FFF, 1'b0);
    run1("max",   24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1);
`ifdef BK_SUB_OVF_EN
    chk("max.ovf", 64'(bus.ovf), 64'd0);
    run1("ovf1", 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0);
    chk("ovf1.ovf", 64'(bus.ovf), 64'd1);
    run1("ovf2", 24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h800000, 1'b1);
    chk("ovf2.ovf", 64'(bus.ovf), 64'd1);
`endif

    // Backpressure: three beats fill the pipe, then in_ready drops
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.in_valid = 1'b1;
      bus.A = 24'(k); bus.B = '0; bus.bin = 1'b0;
      chk("bp.accept", 64'(bus.in_ready), 64'd1);
      step();
    end
    bus.A = 24'd4;
    chk("bp.full",  64'(bus.in_ready),  64'd0);
    chk("bp.valid", 64'(bus.out_valid), 64'd1);
    chk("bp.D1",    64'(bus.D),         64'd1);
    step();
    step();
    chk("bp.hold.D",     64'(bus.D),        64'd1);
    chk("bp.hold.ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.passthru", 64'(bus.in_ready), 64'd1);
    step();
    chk("bp.v2", 64'(bus.out_valid), 64'd1);
    chk("bp.D2", 64'(bus.D), 64'd2);
    bus.A = 24'd5;
    chk("bp.accept5", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp.D3", 64'(bus.D), 64'd3);
    step();
    chk("bp.v4", 64'(bus.out_valid), 64'd1);
    chk("bp.D4", 64'(bus.D), 64'd4);
    step();
    chk("bp.v5", 64'(bus.out_valid), 64'd1);
    chk("bp.D5", 64'(bus.D), 64'd5);
    step();
    chk("bp.empty", 64'(bus.out_valid), 64'd0);

    // Reset while beats are in flight
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.in_valid = 1'b1;
      bus.A = 24'(k * 16); bus.B = '0; bus.bin = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    chk("rmid.pre.valid", 64'(bus.out_valid), 64'd1);
    chk("rmid.pre.D",     64'(bus.D),         64'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid.valid", 64'(bus.out_valid), 64'd0);
    chk("rmid.D",     64'(bus.D),         64'd0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rmid.nostale", 64'(bus.out_valid), 64'd0);
    end

    // Random beats with random backpressure, scoreboarded in order
    sent = 0; got = 0; pass = 0; cyc = 0; need = 1'b1;
    while (got < 50 && cyc < 3000) begin
      if (sent >= 50) begin
        bus.in_valid = 1'b0;
      end else if (need) begin
        bus.A        = 24'($urandom);
        bus.B        = 24'($urandom);
        bus.bin      = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      need = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, bus.A} - {1'b0, bus.B} - {{W{1'b0}}, bus.bin});
        sent++;
        need = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_r = (q.size() > 0) ? q.pop_front() : 'x;
        chk("rnd.beat", 64'({bus.bout, bus.D}), 64'(exp_r));
        if ({bus.bout, bus.D} === exp_r) pass++;
        got++;
      end
      step();
      cyc++;
    end
    chk("rnd.count", 64'(got), 64'd50);
    $display("random: %0d/50 beats matched", pass);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
